// File: rtl/sdf_notifier_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdf_notifier_capture_pkg
// Brief    : Shared timing-check consumer definitions: FSM state encoding and
//            default widths reused by notifier consumers.
// Revision : 1.0 - initial release
// ============================================================================
package sdf_notifier_capture_pkg;

    // Consumer FSM state encoding; value 3 is unused and recovered from.
    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_VIOLATED = 2'd1,
        ST_RECOVER  = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_e;

    // Default configuration for notifier consumers.
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_RECOVER_N = 4;

endpackage : sdf_notifier_capture_pkg
`default_nettype wire

// File: rtl/ntfr_toggle_sync.sv
`default_nettype none
// ============================================================================
// Module   : ntfr_toggle_sync
// Brief    : Two-flop synchroniser plus delay flop on the asynchronous
//            notifier; pulses tog for one cycle per observed level change.
// Revision : 1.0 - initial release
// ============================================================================
module ntfr_toggle_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ntfr,
    output logic tog
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Synchroniser chain; reset preloads the live notifier level so the
    // first cycles after reset never report a phantom toggle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= ntfr;
            r_s2 <= ntfr;
            r_s3 <= ntfr;
        end else begin
            r_s1 <= ntfr;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign tog = r_s2 ^ r_s3;

endmodule : ntfr_toggle_sync
`default_nettype wire

// File: rtl/sdf_notifier_capture.sv
`default_nettype none
// ============================================================================
// Module   : sdf_notifier_capture
// Brief    : Conditional capture register consuming a $setuphold notifier.
//            Detects notifier toggles, invalidates captured data, counts
//            violations and requires RECOVER_N clean captures to recover.
//            Optional feature macro NTFR_LOG_EN adds log_data/log_mode,
//            holding data/mode seen on the most recent violation cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sdf_notifier_capture
    import sdf_notifier_capture_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int RECOVER_N = DEF_RECOVER_N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [WIDTH-1:0] data,
    input  logic             ntfr,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             viol_sticky,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [1:0]       state
`ifdef NTFR_LOG_EN
    ,
    output logic [WIDTH-1:0] log_data,
    output logic             log_mode
`endif
);

    localparam int REC_W = $clog2(RECOVER_N + 1);
    localparam logic [REC_W:0] c_rec_target = RECOVER_N[REC_W:0];

    logic             w_tog;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             r_sticky;
    logic [CNT_W-1:0] r_viol_cnt;
    state_e           r_state;
    logic [REC_W-1:0] r_rec_cnt;

    state_e           w_state_nxt;
    logic [REC_W-1:0] w_rec_nxt;
    logic             w_qv_nxt;
    logic [REC_W:0]   w_rec_inc;

    ntfr_toggle_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .ntfr  (ntfr),
        .tog   (w_tog)
    );

    // Capture register: loads whenever mode is high, even on a violation
    // cycle (the data is kept but flagged untrustworthy by q_valid).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (mode) begin
            r_q <= data;
        end
    end

    // Violation bookkeeping; a toggle beats a simultaneous clear so the
    // event that coincides with clr is still recorded once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_viol_cnt <= '0;
            r_sticky   <= 1'b0;
        end else if (w_tog) begin
            r_sticky <= 1'b1;
            if (clr) begin
                r_viol_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (!(&r_viol_cnt)) begin
                r_viol_cnt <= r_viol_cnt + 1'b1;
            end
        end else if (clr) begin
            r_viol_cnt <= '0;
            r_sticky   <= 1'b0;
        end
    end

    // FSM state register; reset lands in RECOVER so q must be refilled
    // with RECOVER_N captures before it is declared valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RECOVER;
            r_rec_cnt <= '0;
            r_q_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rec_cnt <= w_rec_nxt;
            r_q_valid <= w_qv_nxt;
        end
    end

    // FSM next-state and q_valid decode; a toggle overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        w_rec_nxt   = r_rec_cnt;
        w_qv_nxt    = r_q_valid;
        w_rec_inc   = {1'b0, r_rec_cnt} + 1'b1;
        if (w_tog) begin
            w_state_nxt = ST_VIOLATED;
            w_rec_nxt   = '0;
            w_qv_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_NORMAL: begin
                    w_qv_nxt = 1'b1;
                end
                ST_VIOLATED: begin
                    w_qv_nxt = 1'b0;
                    if (mode) begin
                        // The first clean capture already counts toward recovery.
                        if (c_rec_target <= 1) begin
                            w_state_nxt = ST_NORMAL;
                            w_rec_nxt   = '0;
                            w_qv_nxt    = 1'b1;
                        end else begin
                            w_state_nxt = ST_RECOVER;
                            w_rec_nxt   = {{(REC_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_RECOVER: begin
                    w_qv_nxt = 1'b0;
                    if (mode) begin
                        if (w_rec_inc >= c_rec_target) begin
                            w_state_nxt = ST_NORMAL;
                            w_rec_nxt   = '0;
                            w_qv_nxt    = 1'b1;
                        end else begin
                            w_rec_nxt = w_rec_inc[REC_W-1:0];
                        end
                    end
                end
                default: begin
                    // Unused encoding: treat as an unrecovered violation.
                    w_state_nxt = ST_VIOLATED;
                    w_rec_nxt   = '0;
                    w_qv_nxt    = 1'b0;
                end
            endcase
        end
    end

`ifdef NTFR_LOG_EN
    logic [WIDTH-1:0] r_log_data;
    logic             r_log_mode;

    // Snapshot of the inputs present on the latest violation cycle;
    // deliberately untouched by clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_log_data <= '0;
            r_log_mode <= 1'b0;
        end else if (w_tog) begin
            r_log_data <= data;
            r_log_mode <= mode;
        end
    end

    assign log_data = r_log_data;
    assign log_mode = r_log_mode;
`endif

    assign q           = r_q;
    assign q_valid     = r_q_valid;
    assign viol_sticky = r_sticky;
    assign viol_cnt    = r_viol_cnt;
    assign state       = r_state;

endmodule : sdf_notifier_capture
`default_nettype wire

// File: tb/tb_sdf_notifier_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdf_notifier_capture
// Brief    : Self-checking bench: directed scenarios plus randomized traffic
//            compared against a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdf_notifier_capture;

    localparam int WIDTH     = 8;
    localparam int CNT_W     = 3;
    localparam int RECOVER_N = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int HIST_N    = 8192;

    logic             clk;
    logic             rst_n;
    logic             mode;
    logic [WIDTH-1:0] data;
    logic             ntfr;
    logic             clr;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             viol_sticky;
    logic [CNT_W-1:0] viol_cnt;
    logic [1:0]       state;
`ifdef NTFR_LOG_EN
    logic [WIDTH-1:0] log_data;
    logic             log_mode;
`endif

    sdf_notifier_capture #(
        .WIDTH     (WIDTH),
        .CNT_W     (CNT_W),
        .RECOVER_N (RECOVER_N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .data        (data),
        .ntfr        (ntfr),
        .clr         (clr),
        .q           (q),
        .q_valid     (q_valid),
        .viol_sticky (viol_sticky),
        .viol_cnt    (viol_cnt),
        .state       (state)
`ifdef NTFR_LOG_EN
        ,
        .log_data    (log_data),
        .log_mode    (log_mode)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: notifier level sampled at every edge, violation
    // reported on the edge two cycles after the edge where a new level is
    // first sampled, never looking back past the last reset edge.
    bit       hist [HIST_N];
    int       cyc  = 0;
    int       rcyc = 0;
    int       m_q, m_qv, m_st, m_clean, m_cnt, m_sticky, m_log_data, m_log_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit ev;
        hist[cyc] = ntfr;
        ev = rst_n && (cyc - 3 >= rcyc) && (hist[cyc-2] != hist[cyc-3]);
        if (!rst_n) begin
            m_q = 0; m_qv = 0; m_st = 2; m_clean = 0;
            m_cnt = 0; m_sticky = 0; m_log_data = 0; m_log_mode = 0;
            rcyc = cyc;
        end else begin
            if (mode) m_q = int'(data);
            if (ev) begin
                m_sticky   = 1;
                m_cnt      = clr ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
                m_log_data = int'(data);
                m_log_mode = int'(mode);
                m_st = 1; m_qv = 0; m_clean = 0;
            end else begin
                if (clr) begin
                    m_cnt = 0; m_sticky = 0;
                end
                if (m_st == 0) begin
                    m_qv = 1;
                end else if (mode) begin
                    m_clean = (m_st == 1) ? 1 : m_clean + 1;
                    if (m_clean >= RECOVER_N) begin
                        m_st = 0; m_qv = 1; m_clean = 0;
                    end else begin
                        m_st = 2;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic compare_all();
        check("q",       q,           m_q);
        check("q_valid", q_valid,     m_qv);
        check("sticky",  viol_sticky, m_sticky);
        check("cnt",     viol_cnt,    m_cnt);
        check("state",   state,       m_st);
`ifdef NTFR_LOG_EN
        check("log_data", log_data,   m_log_data);
        check("log_mode", log_mode,   m_log_mode);
`endif
    endtask

    // One clock: inputs already applied, model follows the edge, outputs
    // compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; data = '0; ntfr = 1'b0; clr = 1'b0;
        @(negedge clk);

        // Reset state
        step(); step();
        check("rst_state", state, 2);
        check("rst_qv", q_valid, 0);
        check("rst_cnt", viol_cnt, 0);

        // Fill after reset: q follows after one edge, valid after 4 captures
        rst_n = 1'b1; mode = 1'b1; data = 8'hA5;
        step();
        check("t1_q", q, 8'hA5);
        check("t1_qv_early", q_valid, 0);
        step(); step(); step();
        check("t1_qv", q_valid, 1);
        check("t1_state", state, 0);
        check("t1_cnt", viol_cnt, 0);

        // Single toggle in NORMAL
        mode = 1'b0; ntfr = ~ntfr;
        step(); step();
        check("t2_not_yet", state, 0);
        step();
        check("t2_state", state, 1);
        check("t2_qv", q_valid, 0);
        check("t2_cnt", viol_cnt, 1);
        check("t2_sticky", viol_sticky, 1);

        // clr alone, then clr coinciding with a toggle
        clr = 1'b1; step(); clr = 1'b0;
        check("t5_clr_cnt", viol_cnt, 0);
        check("t5_clr_sticky", viol_sticky, 0);
        ntfr = ~ntfr; step(); step();
        clr = 1'b1; step(); clr = 1'b0;
        check("t5_both_cnt", viol_cnt, 1);
        check("t5_both_sticky", viol_sticky, 1);

        // Recovery interrupted on the third capture
        mode = 1'b1; data = 8'h11; ntfr = ~ntfr;
        step();
        data = 8'h22; step();
        data = 8'h3C; step();
        check("t3_state", state, 1);
        check("t3_cnt", viol_cnt, 2);
        check("t3_q", q, 8'h3C);
`ifdef NTFR_LOG_EN
        check("t3_log", log_data, 8'h3C);
`endif
        for (int i = 0; i < 5; i++) begin
            data = 8'(8'h40 + i);
            step();
        end
        check("t3_rec_state", state, 0);
        check("t3_rec_qv", q_valid, 1);

        // Saturation of the violation counter
        mode = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ntfr = ~ntfr;
            repeat (4) step();
        end
        check("t4_cnt_sat", viol_cnt, CNT_MAX);
        check("t4_sticky", viol_sticky, 1);

        // Reset in RECOVER with the notifier moving
        mode = 1'b1; step();
        check("t6_in_rec", state, 2);
        ntfr = ~ntfr; step();
        rst_n = 1'b0; ntfr = ~ntfr; step();
        check("t6_q", q, 0);
        check("t6_cnt", viol_cnt, 0);
        check("t6_state", state, 2);
        rst_n = 1'b1; mode = 1'b0;
        repeat (5) step();
        check("t6_no_tog", viol_cnt, 0);
        check("t6_state_hold", state, 2);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            mode  = ($urandom_range(0, 3) != 0);
            data  = WIDTH'($urandom);
            clr   = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, (i < 1500) ? 9 : 29) == 0) ntfr = ~ntfr;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sdf_notifier_capture
`default_nettype wire
